// File: rtl/mdio_host_arb_if.sv
// mdio_host_arb_if: requester-side and MAC host-port signals shared by the arbiter
interface mdio_host_arb_if;
  logic req0, req1;
  logic [1:0] opcode0, opcode1;
  logic [9:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic ack0, ack1;
  logic [15:0] rdata;
  logic err;
  logic [1:0] host_opcode;
  logic [9:0] host_addr;
  logic [31:0] host_wr_data;
  logic [31:0] host_rd_data;
  logic host_miim_sel;
  logic host_req;
  logic host_miim_rdy;
  modport master (
    input req0, req1, opcode0, opcode1, addr0, addr1, wdata0, wdata1, host_rd_data, host_miim_rdy,
    output ack0, ack1, rdata, err, host_opcode, host_addr, host_wr_data, host_miim_sel, host_req
  );
  modport slave (
    output req0, req1, opcode0, opcode1, addr0, addr1, wdata0, wdata1, host_rd_data, host_miim_rdy,
    input ack0, ack1, rdata, err, host_opcode, host_addr, host_wr_data, host_miim_sel, host_req
  );
endinterface

// File: rtl/mdio_host_arb.sv
// mdio_host_arb: round-robin sharing of one MAC host/MDIO port between two requesters
module mdio_host_arb #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic host_clk,
  input logic host_reset,
  mdio_host_arb_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;
  state_t state;
  logic gnt, last, pick, tmo, fin_ok, fin_abort, unused_rd;
  logic [15:0] cnt;
  // on a tie the requester not served last wins
  assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;
  assign tmo = cnt == TIMEOUT - 16'd1;
  // an rdy edge on the timeout cycle still counts as progress
  assign fin_ok = state == WAIT_DONE && bus.host_miim_rdy;
  assign fin_abort = tmo && ((state == WAIT_BUSY && bus.host_miim_rdy) || (state == WAIT_DONE && !bus.host_miim_rdy));
  assign unused_rd = ^bus.host_rd_data[31:16];
  // transaction sequencer driving registered host-port and requester outputs
  always_ff @(posedge host_clk or posedge host_reset)
    if (host_reset) begin
      state <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.err <= 1'b0;
      bus.rdata <= '0;
      bus.host_req <= 1'b0;
      bus.host_miim_sel <= 1'b0;
      bus.host_opcode <= '0;
      bus.host_addr <= '0;
      bus.host_wr_data <= '0;
    end else begin
      bus.host_req <= 1'b0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: if (bus.host_miim_rdy && (bus.req0 || bus.req1)) begin
          gnt <= pick;
          bus.host_opcode <= pick ? bus.opcode1 : bus.opcode0;
          bus.host_addr <= pick ? bus.addr1 : bus.addr0;
          bus.host_wr_data <= {16'h0, pick ? bus.wdata1 : bus.wdata0};
          bus.host_req <= 1'b1;
          bus.host_miim_sel <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!bus.host_miim_rdy) begin
          cnt <= '0;
          state <= WAIT_DONE;
        end else if (!tmo) cnt <= cnt + 16'd1;
        WAIT_DONE: if (!bus.host_miim_rdy && !tmo) cnt <= cnt + 16'd1;
        DONE: begin
          last <= gnt;
          bus.err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (fin_ok) bus.rdata <= bus.host_rd_data[15:0];
      if (fin_ok || fin_abort) begin
        bus.ack0 <= ~gnt;
        bus.ack1 <= gnt;
        bus.err <= fin_abort;
        bus.host_miim_sel <= 1'b0;
        state <= DONE;
      end
    end
endmodule
